// File: rtl/scs8hd_engate_ctl_2.sv
// scs8hd_engate_ctl_2 - settle/hold enable controller for a downstream scs8hd_and2b_2 gate.
//
// Turns the level request REQ into a glitch-free, registered active-low enable AN.
// Assertion of the enable waits out a settle window. Removal waits out a hold window.
// ACK reports when the enable has been granted.
//
// Optional feature macro: SC_ENGATE_REQ_SYNC_EN
//   When defined, REQ passes through a 2-flop synchronizer before the FSM, so REQ may be
//   asynchronous. Every latency then grows by exactly 2 cycles.
//
// Parameters:
//   SETTLE_CYC - cycles from accepted request to enable assertion (1..15)
//   HOLD_CYC   - cycles the enable is held after request removal (0..15)
//
// Ports:
//   CLK   - clock, rising edge
//   RESET - asynchronous active-high reset
//   REQ   - level enable request
//   ACK   - enable granted (high only in ON)
//   AN    - active-low enable to the and2b AN pin (low only in ON or HOLD)
//   BUSY  - high in SETTLE and HOLD
//   CNT   - current window counter value, for observation
module scs8hd_engate_ctl_2 #(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ,
  output logic       ACK,
  output logic       AN,
  output logic       BUSY,
  output logic [3:0] CNT
);

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_ON     = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  // Window loads are (cycles - 1), saturated to the 4-bit counter range.
  localparam int unsigned SETTLE_M1 = (SETTLE_CYC == 0) ? 0 : SETTLE_CYC - 1;
  localparam int unsigned HOLD_M1   = (HOLD_CYC == 0) ? 0 : HOLD_CYC - 1;
  localparam logic [3:0]  SETTLE_LOAD = (SETTLE_M1 > 15) ? 4'd15 : 4'(SETTLE_M1);
  localparam logic [3:0]  HOLD_LOAD   = (HOLD_M1 > 15) ? 4'd15 : 4'(HOLD_M1);

  logic       w_req;
  logic [1:0] r_state;
  logic [1:0] w_state_d;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_d;
  logic       r_an;
  logic       r_ack;
  logic       r_busy;
  logic       w_an_d;
  logic       w_ack_d;
  logic       w_busy_d;

`ifdef SC_ENGATE_REQ_SYNC_EN
  logic r_req_s1;
  logic r_req_s2;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_req_s1 <= 1'b0;
      r_req_s2 <= 1'b0;
    end else begin
      r_req_s1 <= REQ;
      r_req_s2 <= r_req_s1;
    end
  end

  assign w_req = r_req_s2;
`else
  assign w_req = REQ;
`endif

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      ST_OFF: begin
        w_cnt_d = 4'd0;
        if (w_req) begin
          w_state_d = ST_SETTLE;
          w_cnt_d   = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (!w_req) begin
          // Abort: request vanished before the window elapsed, no enable pulse.
          w_state_d = ST_OFF;
          w_cnt_d   = 4'd0;
        end else if (r_cnt == 4'd0) begin
          w_state_d = ST_ON;
          w_cnt_d   = 4'd0;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      ST_ON: begin
        w_cnt_d = 4'd0;
        if (!w_req) begin
          if (HOLD_CYC == 0) begin
            w_state_d = ST_OFF;
          end else begin
            w_state_d = ST_HOLD;
            w_cnt_d   = HOLD_LOAD;
          end
        end
      end
      ST_HOLD: begin
        if (w_req) begin
          // Enable is still asserted, so a returning request needs no re-settle.
          w_state_d = ST_ON;
          w_cnt_d   = 4'd0;
        end else if (r_cnt == 4'd0) begin
          w_state_d = ST_OFF;
          w_cnt_d   = 4'd0;
        end else begin
          w_cnt_d = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_d = ST_OFF;
        w_cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs decode the next state so they register on the same edge as the state.
  always_comb begin
    w_an_d   = !((w_state_d == ST_ON) || (w_state_d == ST_HOLD));
    w_ack_d  = (w_state_d == ST_ON);
    w_busy_d = (w_state_d == ST_SETTLE) || (w_state_d == ST_HOLD);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= ST_OFF;
      r_cnt   <= 4'd0;
      r_an    <= 1'b1;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_an    <= w_an_d;
      r_ack   <= w_ack_d;
      r_busy  <= w_busy_d;
    end
  end

  assign AN   = r_an;
  assign ACK  = r_ack;
  assign BUSY = r_busy;
  assign CNT  = r_cnt;

endmodule
